// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module      : instr_fetch_if
// Description : Bundle of the fetch sequencer's control, ROM, LUT and status
//               signals. The master side is the fetch unit; the slave side is
//               the surrounding top level (ROM, decoder, LUT, testbench).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_if #(
  parameter int PC_W = 10,
  parameter int IW   = 9
);
  logic            start;
  logic [PC_W-1:0] start_addr;
  logic            stall;
  logic            branch;
  logic [3:0]      lut_idx;
  logic [PC_W-1:0] lut_target;
  logic [PC_W-1:0] rom_addr;
  logic            rom_en;
  logic [IW-1:0]   rom_data;
  logic [IW-1:0]   instr;
  logic            instr_valid;
  logic [PC_W-1:0] pc;
  logic            done;
  logic [15:0]     retired;

  modport master (
    input  start, start_addr, stall, branch, lut_target, rom_data,
    output lut_idx, rom_addr, rom_en, instr, instr_valid, pc, done, retired
  );

  modport slave (
    output start, start_addr, stall, branch, lut_target, rom_data,
    input  lut_idx, rom_addr, rom_en, instr, instr_valid, pc, done, retired
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : Instruction fetch sequencer. Drives the synchronous ROM,
//               presents fetched words to the decoder, redirects on taken
//               branches through the target LUT, detects HALT and counts
//               retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
  parameter int         PC_W    = 10,
  parameter int         IW      = 9,
  parameter logic [4:0] HALT_OP = 5'b11111
) (
  input  logic         clk,
  input  logic         reset_n,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [PC_W-1:0] C_PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]     C_RET_MAX = 16'hFFFF;

  state_t          state_q, state_d;
  logic [PC_W-1:0] fpc_q, fpc_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic [15:0]     retired_q, retired_d;

  logic            w_accept;
  logic            w_is_halt;
  logic [15:0]     w_ret_inc;

  // The ROM output is the current instruction; holding rom_en low during a
  // stall keeps it stable, so no separate instruction register is needed.
  assign bus.instr       = bus.rom_data;
  assign bus.lut_idx     = bus.rom_data[3:0];
  assign bus.rom_addr    = fpc_q;
  assign bus.rom_en      = ~bus.stall;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.done        = done_q;
  assign bus.retired     = retired_q;

  assign w_accept  = (state_q == S_RUN) && valid_q && !bus.stall;
  assign w_is_halt = (bus.rom_data[IW-1:IW-5] == HALT_OP);
  assign w_ret_inc = (retired_q == C_RET_MAX) ? retired_q : retired_q + 16'd1;

  // State register; reset aborts any fetch in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      fpc_q     <= '0;
      pc_q      <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      retired_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      fpc_q     <= fpc_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic; a stall freezes every register in every state.
  always_comb begin
    state_d   = state_q;
    fpc_d     = fpc_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    done_d    = done_q;
    retired_d = retired_q;

    if (!bus.stall) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          valid_d = 1'b0;
          done_d  = (state_q == S_DONE);
          if (bus.start) begin
            fpc_d     = bus.start_addr;
            retired_d = 16'd0;
            done_d    = 1'b0;
            state_d   = S_FILL;
          end
        end
        S_FILL: begin
          pc_d    = fpc_q;
          fpc_d   = fpc_q + C_PC_ONE;
          valid_d = 1'b1;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (w_accept) begin
            retired_d = w_ret_inc;
            if (w_is_halt) begin
              valid_d = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else if (bus.branch) begin
              // The word arriving next cycle is wrong-path; FILL discards it.
              fpc_d   = bus.lut_target;
              valid_d = 1'b0;
              state_d = S_FILL;
            end else begin
              pc_d  = fpc_q;
              fpc_d = fpc_q + C_PC_ONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
